// File: rtl/fifo_pkg.sv
// Shared FIFO pointer helpers: width-generic Gray/binary conversion.
// Callers zero-extend into MAX_PTR_W and truncate the result back to their own width.
package fifo_pkg;

  localparam int MAX_PTR_W = 17;

  function automatic logic [MAX_PTR_W-1:0] bin2gray(input logic [MAX_PTR_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Leading zeros above the real width leave the low bits of the result unaffected
  function automatic logic [MAX_PTR_W-1:0] gray2bin(input logic [MAX_PTR_W-1:0] g);
    logic [MAX_PTR_W-1:0] b;
    b[MAX_PTR_W-1] = g[MAX_PTR_W-1];
    for (int i = MAX_PTR_W-2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/fifo_wptr_afull_if.sv
// Write-side bus of the FIFO pointer controller.
// The master drives the requests and the synchronised read pointer; the slave returns pointers and flags.
interface fifo_wptr_afull_if #(parameter int ADDR_W = 3);

  logic              winc;
  logic              wovf_clr;
  logic [ADDR_W:0]   wq2_rptr;
  logic [ADDR_W:0]   wptr;
  logic [ADDR_W-1:0] waddr;
  logic              wen;
  logic              wfull;
  logic              walmost_full;
  logic [ADDR_W:0]   wcount;
  logic              woverflow;

  modport master (
    output winc, wovf_clr, wq2_rptr,
    input  wptr, waddr, wen, wfull, walmost_full, wcount, woverflow
  );

  modport slave (
    input  winc, wovf_clr, wq2_rptr,
    output wptr, waddr, wen, wfull, walmost_full, wcount, woverflow
  );

endinterface

// File: rtl/fifo_bin_gray_cntr.sv
// Binary counter with a registered Gray copy, so the Gray output is glitch-free for CDC.
// Next-state values are exported for look-ahead flag logic.
module fifo_bin_gray_cntr
  import fifo_pkg::*;
#(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  output logic [W-1:0] bin_next,
  output logic [W-1:0] gray_next,
  output logic [W-1:0] bin,
  output logic [W-1:0] gray
);

  logic [W-1:0] bin_q, bin_d;
  logic [W-1:0] gray_q, gray_d;

  always_comb begin
    bin_d  = bin_q + W'(en);
    gray_d = W'(bin2gray(MAX_PTR_W'(bin_d)));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bin_q  <= '0;
      gray_q <= '0;
    end else begin
      bin_q  <= bin_d;
      gray_q <= gray_d;
    end
  end

  assign bin_next  = bin_d;
  assign gray_next = gray_d;
  assign bin       = bin_q;
  assign gray      = gray_q;

endmodule

// File: rtl/fifo_wptr_afull.sv
// Write-side pointer and flag controller of the dual-clock FIFO (wclk domain only).
// Produces write address/enable, Gray write pointer, full, almost-full, fill count and sticky overflow.
module fifo_wptr_afull
  import fifo_pkg::*;
#(
  parameter int ADDR_W       = 3,
  parameter int AFULL_THRESH = 6
) (
  input  logic             wclk,
  input  logic             wrst_n,
  fifo_wptr_afull_if.slave wif
);

  localparam int PTR_W = ADDR_W + 1;
  localparam int DEPTH = 2**ADDR_W;
  // Out-of-range thresholds saturate at the depth so the flag still means "nearly full"
  localparam logic [PTR_W-1:0] AFULL_LVL =
    (AFULL_THRESH > DEPTH) ? PTR_W'(DEPTH) : PTR_W'(AFULL_THRESH);

  logic [PTR_W-1:0]  wbin, wbin_next, wgray, wgray_next;
  logic [PTR_W-1:0]  rbin_s, fill_next, full_cmp;
  logic              wen;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic              wfull_q, wfull_d;
  logic              walmost_full_q, walmost_full_d;
  logic              woverflow_q, woverflow_d;

  fifo_bin_gray_cntr #(.W(PTR_W)) u_cntr (
    .clk       (wclk),
    .rst_n     (wrst_n),
    .en        (wen),
    .bin_next  (wbin_next),
    .gray_next (wgray_next),
    .bin       (wbin),
    .gray      (wgray)
  );

  // Full when the next write pointer equals the read pointer with its top two Gray bits inverted
  always_comb begin
    wen            = wif.winc & ~wfull_q;
    rbin_s         = PTR_W'(gray2bin(MAX_PTR_W'(wif.wq2_rptr)));
    full_cmp       = {~wif.wq2_rptr[PTR_W-1:PTR_W-2], wif.wq2_rptr[PTR_W-3:0]};
    fill_next      = wbin_next - rbin_s;
    wfull_d        = (wgray_next == full_cmp);
    walmost_full_d = (fill_next >= AFULL_LVL);
    woverflow_d    = (wif.winc & wfull_q) | (woverflow_q & ~wif.wovf_clr);
    waddr_d        = wbin_next[ADDR_W-1:0];
  end

  always_ff @(posedge wclk) begin
    if (!wrst_n) begin
      waddr_q        <= '0;
      wfull_q        <= 1'b0;
      walmost_full_q <= 1'b0;
      woverflow_q    <= 1'b0;
    end else begin
      waddr_q        <= waddr_d;
      wfull_q        <= wfull_d;
      walmost_full_q <= walmost_full_d;
      woverflow_q    <= woverflow_d;
    end
  end

  assign wif.wen          = wen;
  assign wif.wptr         = wgray;
  assign wif.waddr        = waddr_q;
  assign wif.wfull        = wfull_q;
  assign wif.walmost_full = walmost_full_q;
  assign wif.woverflow    = woverflow_q;
  assign wif.wcount       = wbin - rbin_s;

endmodule

// File: tb/tb_fifo_wptr_afull.sv
// Scoreboard bench for fifo_wptr_afull (ADDR_W=3, AFULL_THRESH=6): directed scenarios then random traffic.
// The reference model tracks write/read totals and derives flags from the fill level.
module tb_fifo_wptr_afull;

  typedef struct {
    logic       wen;
    logic [3:0] wcount;
    logic [3:0] wptr;
    logic [2:0] waddr;
    logic       wfull;
    logic       afull;
    logic       ovf;
    bit         from_reset;
  } exp_t;

  logic wclk = 1'b0;
  logic wrst_n;

  fifo_wptr_afull_if #(.ADDR_W(3)) wif ();

  fifo_wptr_afull #(.ADDR_W(3), .AFULL_THRESH(6)) dut (
    .wclk   (wclk),
    .wrst_n (wrst_n),
    .wif    (wif.slave)
  );

  always #5 wclk = ~wclk;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Model state: writes accepted modulo 16 and the registered flags
  logic [3:0] m_wr = 4'd0;
  bit         m_full = 0, m_afull = 0, m_ovf = 0, m_from_reset = 1;
  int         acc_total = 0;

  function automatic logic [3:0] gray4(input logic [3:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive inputs for the next edge, queue the expected view of the current state, then advance the model
  task automatic applyStimulus(input bit rst_n_i, input bit winc_i, input bit clr_i, input logic [3:0] rd_i);
    exp_t       e;
    logic [3:0] fill_n;
    bit         acc;
    @(posedge wclk);
    #1;
    wrst_n       = rst_n_i;
    wif.winc     = winc_i;
    wif.wovf_clr = clr_i;
    wif.wq2_rptr = gray4(rd_i);
    e.wen        = winc_i & ~m_full;
    e.wcount     = m_wr - rd_i;
    e.wptr       = gray4(m_wr);
    e.waddr      = m_wr[2:0];
    e.wfull      = m_full;
    e.afull      = m_afull;
    e.ovf        = m_ovf;
    e.from_reset = m_from_reset;
    sb_q.push_back(e);
    if (!rst_n_i) begin
      m_wr = 4'd0; m_full = 0; m_afull = 0; m_ovf = 0; m_from_reset = 1;
      acc_total = 0;
    end else begin
      acc   = winc_i && !m_full;
      m_ovf = (winc_i && m_full) || (m_ovf && !clr_i);
      if (acc) begin
        m_wr = m_wr + 4'd1;
        acc_total++;
      end
      fill_n       = m_wr - rd_i;
      m_full       = (fill_n == 4'd8);
      m_afull      = (fill_n >= 4'd6);
      m_from_reset = 0;
    end
  endtask

  // Monitor: compare every presented state against the scoreboard, plus the one-bit Gray step rule
  initial begin
    exp_t       e;
    logic [3:0] prev_wptr;
    bit         have_prev;
    have_prev = 0;
    prev_wptr = 4'd0;
    forever begin
      @(negedge wclk);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        checkOutput("wen",          32'(wif.wen),          32'(e.wen));
        checkOutput("wcount",       32'(wif.wcount),       32'(e.wcount));
        checkOutput("wptr",         32'(wif.wptr),         32'(e.wptr));
        checkOutput("waddr",        32'(wif.waddr),        32'(e.waddr));
        checkOutput("wfull",        32'(wif.wfull),        32'(e.wfull));
        checkOutput("walmost_full", 32'(wif.walmost_full), 32'(e.afull));
        checkOutput("woverflow",    32'(wif.woverflow),    32'(e.ovf));
        if (have_prev && !e.from_reset)
          checkOutput("wptr_one_bit_step", 32'($countones(prev_wptr ^ wif.wptr) <= 1), 32'd1);
        prev_wptr = wif.wptr;
        have_prev = 1;
      end
    end
  end

  initial begin
    int rd_abs;
    wrst_n       = 1'b0;
    wif.winc     = 1'b1;
    wif.wovf_clr = 1'b0;
    wif.wq2_rptr = 4'($urandom);

    // Reset with write request and garbage read pointer
    applyStimulus(0, 1, 0, 4'($urandom));
    applyStimulus(1, 0, 0, 4'd0);
    #2;
    checkOutput("dir_reset_wptr", 32'(wif.wptr), 32'd0);
    checkOutput("dir_reset_wen",  32'(wif.wen),  32'd0);

    // Fill from empty
    for (int i = 0; i < 8; i++) applyStimulus(1, 1, 0, 4'd0);

    // Overflow while full, then set-beats-clear, then clear
    applyStimulus(1, 1, 0, 4'd0);
    #2;
    checkOutput("dir_full_wptr",   32'(wif.wptr),   32'hC);
    checkOutput("dir_full_wcount", 32'(wif.wcount), 32'd8);
    checkOutput("dir_full_flag",   32'(wif.wfull),  32'd1);
    applyStimulus(1, 1, 0, 4'd0);
    applyStimulus(1, 1, 1, 4'd0);
    applyStimulus(1, 0, 1, 4'd0);
    #2;
    checkOutput("dir_ovf_set_wins", 32'(wif.woverflow), 32'd1);

    // Drain: read pointer reaches binary 3
    applyStimulus(1, 0, 0, 4'd3);
    #2;
    checkOutput("dir_ovf_cleared", 32'(wif.woverflow), 32'd0);
    checkOutput("dir_drain_count", 32'(wif.wcount),    32'd5);
    applyStimulus(1, 0, 0, 4'd3);
    #2;
    checkOutput("dir_drain_full",  32'(wif.wfull),        32'd0);
    checkOutput("dir_drain_afull", 32'(wif.walmost_full), 32'd0);

    // Wrap: empty the FIFO at read pointer 8, then write 8 more so wbin wraps to 0
    applyStimulus(1, 0, 0, 4'd8);
    for (int i = 0; i < 8; i++) applyStimulus(1, 1, 0, 4'd8);
    applyStimulus(1, 0, 0, 4'd8);
    #2;
    checkOutput("dir_wrap_wptr",   32'(wif.wptr),   32'd0);
    checkOutput("dir_wrap_full",   32'(wif.wfull),  32'd1);
    checkOutput("dir_wrap_wcount", 32'(wif.wcount), 32'd8);

    // Mid-operation reset after 5 writes
    applyStimulus(1, 0, 0, 4'd0);
    for (int i = 0; i < 5; i++) applyStimulus(1, 1, 0, 4'd0);
    applyStimulus(0, 0, 0, 4'd0);
    applyStimulus(1, 1, 0, 4'd0);
    #2;
    checkOutput("dir_mrst_waddr",  32'(wif.waddr),  32'd0);
    checkOutput("dir_mrst_wcount", 32'(wif.wcount), 32'd0);
    applyStimulus(1, 1, 0, 4'd0);
    applyStimulus(1, 1, 0, 4'd0);
    applyStimulus(1, 0, 0, 4'd0);
    #2;
    checkOutput("dir_resume_waddr", 32'(wif.waddr), 32'd3);

    // Random traffic with a lagging legal read pointer
    rd_abs = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        rd_abs = 0;
        applyStimulus(0, 1'($urandom_range(0, 1)), 0, 4'd0);
      end else begin
        if (rd_abs < acc_total && $urandom_range(0, 1) == 1) rd_abs++;
        applyStimulus(1, $urandom_range(0, 99) < 60, $urandom_range(0, 7) == 0, 4'(rd_abs));
      end
    end

    applyStimulus(1, 0, 0, 4'(rd_abs));
    @(negedge wclk);
    @(negedge wclk);
    checkOutput("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
